// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default address / data widths
//   BURST_W                 : width of the port-0 burst counter
//   owner_e                 : which port owns a command (OWN_P0, OWN_P1)
//   cmd_t                   : registered memory command (valid, owner, we, addr, wdata)
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned BURST_W    = 4;

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_e;

    // Sized for the default widths; the top level casts into and out of it.
    typedef struct packed {
        logic                  valid;
        owner_e                owner;
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Fixed-priority grant logic with a burst cap for the data-memory arbiter.
// Port 0 wins contention until it has taken MAX_BURST consecutive grants while
// port 1 was waiting; the next contended cycle then goes to port 1.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   p0_req, p1_req   : access requests
//   p0_gnt, p1_gnt   : combinational grants (at most one high, never without req)
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p0_req,
    input  logic p1_req,
    output logic p0_gnt,
    output logic p1_gnt
);

    localparam logic [BURST_W-1:0] MaxBurst = BURST_W'(MAX_BURST);

    logic [BURST_W-1:0] burst_q, burst_d;
    logic               cap_hit;

    always_comb begin
        cap_hit = (burst_q == MaxBurst);
        p0_gnt  = p0_req & ~(p1_req & cap_hit);
        p1_gnt  = p1_req & ~(p0_req & ~cap_hit);

        // While p1 waits exactly one port is granted each cycle, so the count
        // can only reach MaxBurst before a p1 grant clears it.
        burst_d = burst_q;
        if (!p1_req || p1_gnt) begin
            burst_d = '0;
        end else if (p0_gnt) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 256x8 data memory.
// Grant -> command register drives the memory for one cycle -> response
// register presents done/rdata to the owning port one cycle later.
// Optional build macro DMEM_ARB_STATS_EN adds per-port saturating grant counters.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   pN_req/we/addr/wdata             : port N request (held until granted)
//   pN_gnt                           : combinational grant, transfer on req & gnt
//   pN_done / pN_rdata               : completion pulse and read data (0 for writes)
//   mem_address/write_data/write/read: memory command, all 0 when idle
//   mem_read_data                    : combinational memory read data
//   stats_clr, pN_grant_cnt          : (DMEM_ARB_STATS_EN only) clear and grant counts
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DMEM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       p0_grant_cnt,
    output logic [15:0]       p1_grant_cnt,
`endif
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    cmd_t              cmd_q, cmd_d;
    logic              rsp_valid_q, rsp_valid_d;
    owner_e            rsp_owner_q, rsp_owner_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    dmem_arb_prio #(
        .MAX_BURST (MAX_BURST)
    ) u_prio (
        .clk    (clk),
        .rst_n  (rst_n),
        .p0_req (p0_req),
        .p1_req (p1_req),
        .p0_gnt (p0_gnt),
        .p1_gnt (p1_gnt)
    );

    // Idle cycles load an all-zero command, so the memory outputs can pass
    // straight through and still read as 0 whenever valid is low.
    always_comb begin
        cmd_d = '0;
        if (p0_gnt) begin
            cmd_d.valid = 1'b1;
            cmd_d.owner = OWN_P0;
            cmd_d.we    = p0_we;
            cmd_d.addr  = DEF_ADDR_W'(p0_addr);
            cmd_d.wdata = DEF_DATA_W'(p0_wdata);
        end else if (p1_gnt) begin
            cmd_d.valid = 1'b1;
            cmd_d.owner = OWN_P1;
            cmd_d.we    = p1_we;
            cmd_d.addr  = DEF_ADDR_W'(p1_addr);
            cmd_d.wdata = DEF_DATA_W'(p1_wdata);
        end
    end

    always_comb begin
        mem_read       = cmd_q.valid & ~cmd_q.we;
        mem_write      = cmd_q.valid & cmd_q.we;
        mem_address    = ADDR_W'(cmd_q.addr);
        mem_write_data = DATA_W'(cmd_q.wdata);

        rsp_valid_d = cmd_q.valid;
        rsp_owner_d = cmd_q.owner;
        rsp_rdata_d = mem_read ? mem_read_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= OWN_P0;
            rsp_rdata_q <= '0;
        end else begin
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        p0_done  = rsp_valid_q & (rsp_owner_q == OWN_P0);
        p1_done  = rsp_valid_q & (rsp_owner_q == OWN_P1);
        p0_rdata = p0_done ? rsp_rdata_q : '0;
        p1_rdata = p1_done ? rsp_rdata_q : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] p0_cnt_q, p0_cnt_d;
    logic [15:0] p1_cnt_q, p1_cnt_d;

    always_comb begin
        p0_cnt_d = p0_cnt_q;
        p1_cnt_d = p1_cnt_q;
        if (stats_clr) begin
            p0_cnt_d = '0;
            p1_cnt_d = '0;
        end else begin
            if (p0_gnt && (p0_cnt_q != 16'hFFFF)) p0_cnt_d = p0_cnt_q + 16'd1;
            if (p1_gnt && (p1_cnt_q != 16'hFFFF)) p1_cnt_d = p1_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_cnt_q <= '0;
            p1_cnt_q <= '0;
        end else begin
            p0_cnt_q <= p0_cnt_d;
            p1_cnt_q <= p1_cnt_d;
        end
    end

    assign p0_grant_cnt = p0_cnt_q;
    assign p1_grant_cnt = p1_cnt_q;
`endif

endmodule
